// File: rtl/mc_ctrl_seq_pkg.sv
// Shared types and constants for the mc_ctrl_seq control sequencer.
// Holds the one-hot state ring, instruction classes, opcode map and pc_sel codes.
package mc_ctrl_seq_pkg;

  localparam int NSTATE_RING = 5;

  typedef enum logic [NSTATE_RING-1:0] {
    ST_IF  = 5'b00001,
    ST_ID  = 5'b00010,
    ST_EX  = 5'b00100,
    ST_MEM = 5'b01000,
    ST_WB  = 5'b10000
  } state_e;

  typedef enum logic [3:0] {
    CL_R     = 4'd0,
    CL_I     = 4'd1,
    CL_L     = 4'd2,
    CL_S     = 4'd3,
    CL_B     = 4'd4,
    CL_JAL   = 4'd5,
    CL_JALR  = 4'd6,
    CL_LUI   = 4'd7,
    CL_AUIPC = 4'd8,
    CL_MD    = 4'd9,
    CL_ILL   = 4'd10
  } class_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  function automatic logic writes_rd(class_e c);
    case (c)
      CL_S, CL_B, CL_ILL: return 1'b0;
      default:            return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_seq_if.sv
// Handshake/strobe bundle between mc_ctrl_seq and the datapath.
// md_start/md_done exist only when MULDIV_EN is defined.
interface mc_ctrl_seq_if #(parameter int NSTATE = 5);
  logic              hold;
  logic              flush;
  logic [31:0]       inst;
  logic              jc;
  logic              mem_ready;
  logic [NSTATE-1:0] state;
  logic              imem_req;
  logic              inst_latch;
  logic              dmem_rd;
  logic              dmem_wr;
  logic              reg_wen;
  logic [1:0]        pc_sel;
  logic              retire;
  logic              illegal;
  logic              timeout;
`ifdef MULDIV_EN
  logic              md_start;
  logic              md_done;

  modport master (input hold, flush, inst, jc, mem_ready, md_done,
                  output state, imem_req, inst_latch, dmem_rd, dmem_wr, reg_wen,
                         pc_sel, retire, illegal, timeout, md_start);
  modport slave  (output hold, flush, inst, jc, mem_ready, md_done,
                  input state, imem_req, inst_latch, dmem_rd, dmem_wr, reg_wen,
                        pc_sel, retire, illegal, timeout, md_start);
`else
  modport master (input hold, flush, inst, jc, mem_ready,
                  output state, imem_req, inst_latch, dmem_rd, dmem_wr, reg_wen,
                         pc_sel, retire, illegal, timeout);
  modport slave  (output hold, flush, inst, jc, mem_ready,
                  input state, imem_req, inst_latch, dmem_rd, dmem_wr, reg_wen,
                        pc_sel, retire, illegal, timeout);
`endif
endinterface

// File: rtl/mc_ctrl_seq_decode.sv
// Combinational instruction classifier for the sequencer (opcode/funct3/funct7 only).
// With MULDIV_EN defined, OP encodings with funct7=0000001 classify as MD, otherwise illegal.
module mc_ctrl_seq_decode
  import mc_ctrl_seq_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output class_e     class_o
);

  always_comb begin
    class_o = CL_ILL;
    case (opcode_i)
      OP_R: begin
        if (funct7_i == 7'b0000000 || funct7_i == 7'b0100000) class_o = CL_R;
`ifdef MULDIV_EN
        else if (funct7_i == 7'b0000001) class_o = CL_MD;
`endif
      end
      OP_I:     class_o = CL_I;
      OP_L:     if (funct3_i != 3'b011 && funct3_i[2:1] != 2'b11) class_o = CL_L;
      OP_S:     if (funct3_i[2] == 1'b0 && funct3_i != 3'b011) class_o = CL_S;
      OP_B:     if (funct3_i[2:1] != 2'b01) class_o = CL_B;
      OP_JAL:   class_o = CL_JAL;
      OP_JALR:  if (funct3_i == 3'b000) class_o = CL_JALR;
      OP_LUI:   class_o = CL_LUI;
      OP_AUIPC: class_o = CL_AUIPC;
      default:  class_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// One-hot IF/ID/EX/MEM/WB control sequencer with memory wait counter and timeout.
// Optional multiply/divide wait in EX is built when MULDIV_EN is defined.
//
// state | meaning
// IF    | fetch request until mem_ready, then latch IR
// ID    | classify inst, illegal opcodes return to IF
// EX    | resolve branch taken; MD ops wait for md_done
// MEM   | load/store request until mem_ready
// WB    | register write, pc select, retire
module mc_ctrl_seq
  import mc_ctrl_seq_pkg::*;
#(
  parameter int TO_W   = 4,
  parameter int NSTATE = 5
) (
  input  logic          clk,
  input  logic          rstn,
  mc_ctrl_seq_if.master ctrl_io
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'((2 ** TO_W) - 2);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            taken_q, taken_d;
  class_e          class_q, class_d;
  class_e          dec_class;

  logic go, wait_rdy, md_wait, in_wait, expire;
  logic imem_req, inst_latch, dmem_rd, dmem_wr, reg_wen, retire, illegal;
  logic [1:0] pc_sel;

  mc_ctrl_seq_decode u_decode (
    .opcode_i (ctrl_io.inst[6:0]),
    .funct3_i (ctrl_io.inst[14:12]),
    .funct7_i (ctrl_io.inst[31:25]),
    .class_o  (dec_class)
  );

  // IF, MEM and an MD op in EX share the wait counter; the ready source differs.
`ifdef MULDIV_EN
  assign md_wait  = (state_q == ST_EX) && (class_q == CL_MD);
  assign wait_rdy = (state_q == ST_EX) ? ctrl_io.md_done : ctrl_io.mem_ready;
`else
  assign md_wait  = 1'b0;
  assign wait_rdy = ctrl_io.mem_ready;
`endif

  assign go      = !ctrl_io.hold && !ctrl_io.flush;
  assign in_wait = (state_q == ST_IF) || (state_q == ST_MEM) || md_wait;
  assign expire  = in_wait && go && !wait_rdy && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IF;
      cnt_q   <= '0;
      taken_q <= 1'b0;
      class_q <= CL_R;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    taken_d    = taken_q;
    class_d    = class_q;
    imem_req   = 1'b0;
    inst_latch = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    reg_wen    = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    pc_sel     = PC_SEQ;

    if (ctrl_io.flush) begin
      state_d = ST_IF;
      cnt_d   = '0;
    end else if (!ctrl_io.hold) begin
      if (in_wait) begin
        if (wait_rdy) begin
          state_d = (state_q == ST_IF) ? ST_ID : ST_WB;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        case (state_q)
          ST_ID: begin
            class_d = dec_class;
            state_d = (dec_class == CL_ILL) ? ST_IF : ST_EX;
          end
          ST_EX:   state_d = (class_q == CL_L || class_q == CL_S) ? ST_MEM : ST_WB;
          default: state_d = ST_IF;
        endcase
      end
      if (state_q == ST_EX)
        taken_d = ((class_q == CL_B) && ctrl_io.jc) || (class_q == CL_JAL);
    end

    // Requests drop only on hold; one-cycle strobes also drop on flush.
    imem_req   = (state_q == ST_IF) && !ctrl_io.hold;
    inst_latch = (state_q == ST_IF) && ctrl_io.mem_ready && go;
    dmem_rd    = (state_q == ST_MEM) && (class_q == CL_L) && !ctrl_io.hold;
    dmem_wr    = (state_q == ST_MEM) && (class_q == CL_S) && !ctrl_io.hold;
    illegal    = (state_q == ST_ID) && (dec_class == CL_ILL) && go;
    if ((state_q == ST_WB) && go) begin
      retire  = 1'b1;
      reg_wen = writes_rd(class_q);
      if (class_q == CL_JALR) pc_sel = PC_REG;
      else if (taken_q)       pc_sel = PC_REL;
    end
  end

  assign ctrl_io.state      = NSTATE'(state_q);
  assign ctrl_io.imem_req   = imem_req;
  assign ctrl_io.inst_latch = inst_latch;
  assign ctrl_io.dmem_rd    = dmem_rd;
  assign ctrl_io.dmem_wr    = dmem_wr;
  assign ctrl_io.reg_wen    = reg_wen;
  assign ctrl_io.pc_sel     = pc_sel;
  assign ctrl_io.retire     = retire;
  assign ctrl_io.illegal    = illegal;
  assign ctrl_io.timeout    = expire;
`ifdef MULDIV_EN
  assign ctrl_io.md_start   = md_wait && (cnt_q == '0) && !ctrl_io.hold;
`endif

endmodule
